// File: rtl/code_conv_pkg.sv
// Shared types and constants for the code-conversion arbiter and its engine.
package code_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/code_conv_arbiter_if.sv
// Requester and response channel bundle of the code-conversion arbiter.
interface code_conv_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_mode;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_mode;
    logic                     busy;

    modport master (
        output req_valid, req_data, req_mode, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_mode, busy
    );

    modport slave (
        input  req_valid, req_data, req_mode, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_mode, busy
    );

endinterface

// File: rtl/code_conv_core.sv
// Conversion engine: one-cycle binary->Gray, or MSB-first bit-serial Gray->binary.
module code_conv_core
    import code_conv_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             done_o,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    cnt_o
);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic             active_q;
    logic             mode_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] b_q;
    logic             b_bit;

    // g_q shifts left so its MSB is always the Gray bit for the current step;
    // b_q[0] holds the binary bit decoded on the previous step.
    assign b_bit = ((cnt_q == '0) ? 1'b0 : b_q[0]) ^ g_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            mode_q   <= MODE_B2G;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                active_q <= 1'b1;
                mode_q   <= mode_i;
                cnt_q    <= '0;
            end else if (active_q) begin
                if (mode_q == MODE_B2G || cnt_q == CW'(WIDTH - 1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            g_q <= din_i;
        end else if (active_q) begin
            if (mode_q == MODE_B2G) begin
                b_q <= bin2gray(g_q);
            end else begin
                b_q <= {b_q[WIDTH-2:0], b_bit};
                g_q <= g_q << 1;
            end
        end
    end

    assign done_o = done_q;
    assign dout_o = b_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter sharing one code-conversion engine between NUM_REQ
// requesters, one transaction in flight, result returned on a tagged channel.
module code_conv_arbiter
    import code_conv_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input logic                clk,
    input logic                rst_n,
    code_conv_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int CW   = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  id_q;
    logic             mode_q;
    logic [WIDTH-1:0] data_q;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [WIDTH-1:0] grant_data;
    logic             grant_mode;
    logic [ID_W:0]    scan_sum;
    logic             hs;

    logic             core_done;
    logic [WIDTH-1:0] core_dout;
    logic [CW-1:0]    core_cnt;
    logic             conv_done;

    // Scan from rr_q upward, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_q} + (ID_W + 1)'(k);
            if (scan_sum >= (ID_W + 1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W + 1)'(NUM_REQ);
            end
            if (!grant_vld && bus.req_valid[scan_sum[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_mode = MODE_B2G;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                grant_data = bus.req_data[k*WIDTH +: WIDTH];
                grant_mode = bus.req_mode[k];
            end
        end
    end

    assign hs   = (state_q == IDLE) && grant_vld;
    assign rr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    code_conv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (hs),
        .mode_i  (grant_mode),
        .din_i   (grant_data),
        .done_o  (core_done),
        .dout_o  (core_dout),
        .cnt_o   (core_cnt)
    );

    // A serial result is only accepted once the engine has walked every bit.
    assign conv_done = core_done && (mode_q == MODE_B2G || core_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld)      state_d = CONV;
            CONV:    if (conv_done)      state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = (state_q == RESP);
        bus.busy       = (state_q != IDLE);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hs && grant_id == ID_W'(k)) begin
                bus.req_ready[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            id_q   <= '0;
            mode_q <= MODE_B2G;
            data_q <= '0;
        end else begin
            if (hs) begin
                rr_q   <= rr_d;
                id_q   <= grant_id;
                mode_q <= grant_mode;
            end
            if (conv_done) begin
                data_q <= core_dout;
            end
        end
    end

    assign bus.resp_data = data_q;
    assign bus.resp_id   = id_q;
    assign bus.resp_mode = mode_q;

endmodule
